// File: rtl/ofdm_rx_pkg.sv
// ofdm_rx_pkg
// Definitions shared by the Rx demapper and the frame sequencer in front of it:
//   - default frame geometry (samples per symbol, symbols per frame, preamble length)
//   - frame sequencer state encoding (frame_state_t)
//   - demapper configuration record demap_cfg_t = {ss, m, bw}
//   - bw_legal(): bandwidth indices 0..6 are legal, 7 is reserved
package ofdm_rx_pkg;

  localparam int DEF_SYMB_LEN   = 1024;
  localparam int DEF_FRAME_SIZE = 50;
  localparam int DEF_N_PREAM    = 2;

  localparam logic [2:0] BW_MAX = 3'd6;

  // State encodings are fixed so they stay stable for debug tooling.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_PREAM    = 2'd2;
  localparam logic [1:0] S_DATA     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = S_IDLE,
    ST_WAIT_SOF = S_WAIT_SOF,
    ST_PREAM    = S_PREAM,
    ST_DATA     = S_DATA
  } frame_state_t;

  typedef struct packed {
    logic [3:0] ss;
    logic [2:0] m;
    logic [2:0] bw;
  } demap_cfg_t;

  function automatic logic bw_legal(input logic [2:0] bw);
    return (bw <= BW_MAX);
  endfunction

endpackage

// File: rtl/demap_cfg_shadow.sv
// demap_cfg_shadow
// One-entry pending register for demapper configuration.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   cfg_valid/ready : configuration handshake
//   cfg_ss/m/bw     : offered configuration
//   consume         : frame start strobe; empties the pending entry
//   pending_vld     : a configuration is held and waiting for a frame start
//   pending         : the held configuration
//   err_cfg         : one-cycle pulse, an illegal bandwidth index was accepted
//
// Handshake: a transfer happens on every edge where cfg_valid & cfg_ready are
// both high. cfg_ready is high exactly when no configuration is pending, and
// depends only on registered state (never on cfg_valid). The offering side must
// hold cfg_* stable while cfg_valid is high and cfg_ready low.
module demap_cfg_shadow
  import ofdm_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_ss,
  input  logic [2:0] cfg_m,
  input  logic [2:0] cfg_bw,
  input  logic       consume,
  output logic       pending_vld,
  output demap_cfg_t pending,
  output logic       err_cfg
);

  logic accept;
  logic legal;

  assign cfg_ready = ~pending_vld;
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = bw_legal(cfg_bw);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_vld <= 1'b0;
      pending     <= '0;
      err_cfg     <= 1'b0;
    end else begin
      // Illegal configurations complete the handshake but are dropped.
      err_cfg <= accept & ~legal;
      // accept implies the register is empty, so it never races a consume.
      if (accept && legal) begin
        pending_vld <= 1'b1;
        pending     <= '{ss: cfg_ss, m: cfg_m, bw: cfg_bw};
      end else if (consume) begin
        pending_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demap_frame_ctrl.sv
// demap_frame_ctrl
// Frame sequencer in front of the Rx demapper. Tracks sample and symbol
// position inside a frame, forwards samples with a one-cycle registered
// latency, and applies configuration only at frame starts.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   start                 : level, arms frame acquisition
//   frame_sync, ival, isop: input stream markers
//   subc_i, subc_q        : input samples
//   cfg_*                 : configuration handshake (see demap_cfg_shadow)
//   oval, osop, osubc_*   : forwarded stream
//   frame_counter         : symbol index in the frame of the forwarded sample
//   enable                : demapper subcarrier-counter enable (equals oval)
//   index_ss/M/bw         : configuration of the current frame
//   busy                  : in preamble or data part of a frame
//   frame_done, err_len   : one-cycle pulses aligned with the output stream
//   err_cfg               : one-cycle pulse, illegal configuration dropped
//   fsm_state             : current state, for debug
module demap_frame_ctrl
  import ofdm_rx_pkg::*;
#(
  parameter int SYMB_LEN   = DEF_SYMB_LEN,
  parameter int FRAME_SIZE = DEF_FRAME_SIZE,
  parameter int N_PREAM    = DEF_N_PREAM,
  parameter int fft_depth  = 12
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 frame_sync,
  input  logic                 ival,
  input  logic                 isop,
  input  logic [fft_depth-1:0] subc_i,
  input  logic [fft_depth-1:0] subc_q,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_ss,
  input  logic [2:0]           cfg_m,
  input  logic [2:0]           cfg_bw,
  output logic                 oval,
  output logic                 osop,
  output logic [fft_depth-1:0] osubc_i,
  output logic [fft_depth-1:0] osubc_q,
  output logic [6:0]           frame_counter,
  output logic                 enable,
  output logic [3:0]           index_ss,
  output logic [2:0]           index_M,
  output logic [2:0]           index_bw,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_len,
  output logic                 err_cfg,
  output frame_state_t         fsm_state
);

  localparam int CNT_W = $clog2(SYMB_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(SYMB_LEN);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [6:0]       FC_LAST = 7'(FRAME_SIZE - 1);
  localparam logic [6:0]       NP_C    = 7'(N_PREAM);

  frame_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [6:0]       fc_nxt;
  logic             fwd, sop_nxt, err_nxt, last_nxt, frame_start;

  logic       pending_vld;
  demap_cfg_t pending;

  demap_cfg_shadow u_cfg_shadow (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ss      (cfg_ss),
    .cfg_m       (cfg_m),
    .cfg_bw      (cfg_bw),
    .consume     (frame_start),
    .pending_vld (pending_vld),
    .pending     (pending),
    .err_cfg     (err_cfg)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    fc_nxt      = frame_counter;
    fwd         = 1'b0;
    sop_nxt     = 1'b0;
    err_nxt     = 1'b0;
    frame_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else if (ival && isop && frame_sync) begin
          frame_start = 1'b1;
          fwd         = 1'b1;
          sop_nxt     = 1'b1;
          cnt_nxt     = ONE_C;
          fc_nxt      = 7'd0;
          state_nxt   = (N_PREAM == 0) ? ST_DATA : ST_PREAM;
        end
      end
      ST_PREAM, ST_DATA: begin
        if (ival) begin
          if (isop) begin
            if (cnt == LEN_C) begin
              fwd     = 1'b1;
              sop_nxt = 1'b1;
              cnt_nxt = ONE_C;
              fc_nxt  = frame_counter + 7'd1;
              if (state == ST_PREAM && fc_nxt == NP_C) state_nxt = ST_DATA;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_WAIT_SOF;
            end
          end else if (cnt == LEN_C) begin
            // Symbol full but no isop: the stream has lost alignment.
            err_nxt   = 1'b1;
            state_nxt = ST_WAIT_SOF;
          end else begin
            fwd     = 1'b1;
            cnt_nxt = cnt + ONE_C;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Checked on the post-update counters so degenerate geometries
    // (one-sample symbols, one-symbol frames) also terminate correctly.
    last_nxt = fwd && (fc_nxt == FC_LAST) && (cnt_nxt == LEN_C);
    if (last_nxt) state_nxt = start ? ST_WAIT_SOF : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      frame_counter <= 7'd0;
      oval          <= 1'b0;
      osop          <= 1'b0;
      enable        <= 1'b0;
      frame_done    <= 1'b0;
      err_len       <= 1'b0;
      osubc_i       <= '0;
      osubc_q       <= '0;
      index_ss      <= 4'd0;
      index_M       <= 3'd0;
      index_bw      <= 3'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      frame_counter <= fc_nxt;
      oval          <= fwd;
      osop          <= sop_nxt;
      enable        <= fwd;
      frame_done    <= last_nxt;
      err_len       <= err_nxt;
      if (fwd) begin
        osubc_i <= subc_i;
        osubc_q <= subc_q;
      end
      // Without a pending configuration the previous frame's settings stay.
      if (frame_start && pending_vld) begin
        index_ss <= pending.ss;
        index_M  <= pending.m;
        index_bw <= pending.bw;
      end
    end
  end

  assign busy      = (state == ST_PREAM) || (state == ST_DATA);
  assign fsm_state = state;

endmodule

// File: tb/tb_demap_frame_ctrl.sv
module tb_demap_frame_ctrl;
  import ofdm_rx_pkg::*;

  localparam int SL = 8;
  localparam int FS = 6;
  localparam int NP = 2;
  localparam int W  = 12;

  typedef struct packed {
    logic       oval;
    logic       osop;
    logic       en;
    logic [6:0] fc;
    logic       done;
    logic       err;
    logic       busy;
    logic       rdy;
    logic       ecfg;
    logic [3:0] ss;
    logic [2:0] m;
    logic [2:0] bw;
  } ctl_t;

  typedef struct packed {
    ctl_t         c;
    logic [W-1:0] di;
    logic [W-1:0] dq;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic clk = 1'b0;
  logic rst, start, frame_sync, ival, isop;
  logic [W-1:0] subc_i, subc_q;
  logic cfg_valid, cfg_ready;
  logic [3:0] cfg_ss;
  logic [2:0] cfg_m, cfg_bw;
  logic oval, osop, enable, busy, frame_done, err_len, err_cfg;
  logic [W-1:0] osubc_i, osubc_q;
  logic [6:0] frame_counter;
  logic [3:0] index_ss;
  logic [2:0] index_M, index_bw;
  frame_state_t fsm_state;

  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Expected configuration side, tracked from the handshake rules.
  logic       m_pvld  = 1'b0;
  logic       m_ready = 1'b1;
  logic [9:0] m_pend  = '0;
  logic [9:0] m_idx   = '0;
  logic [6:0] fc_hold = 7'd0;

  demap_frame_ctrl #(
    .SYMB_LEN(SL), .FRAME_SIZE(FS), .N_PREAM(NP), .fft_depth(W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_sync(frame_sync),
    .ival(ival), .isop(isop), .subc_i(subc_i), .subc_q(subc_q),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ss(cfg_ss), .cfg_m(cfg_m), .cfg_bw(cfg_bw),
    .oval(oval), .osop(osop), .osubc_i(osubc_i), .osubc_q(osubc_q),
    .frame_counter(frame_counter), .enable(enable),
    .index_ss(index_ss), .index_M(index_M), .index_bw(index_bw),
    .busy(busy), .frame_done(frame_done), .err_len(err_len),
    .err_cfg(err_cfg), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic ctl_t observed_ctl();
    ctl_t o;
    o = {oval, osop, enable, frame_counter, frame_done, err_len, busy,
         cfg_ready, err_cfg, index_ss, index_M, index_bw};
    return o;
  endfunction

  // One clock: inputs already set by the caller (at a negedge). Expected
  // outputs are pushed, then popped and compared at the following negedge.
  task automatic cyc(input string tag, input logic fstart, input logic e_oval,
                     input logic e_osop, input logic [6:0] e_fc, input logic e_done,
                     input logic e_err, input logic e_busy);
    exp_t e;
    exp_t g;
    logic acc;
    acc = cfg_valid && m_ready;
    e.c.ecfg = acc && (cfg_bw == 3'd7);
    if (fstart && m_pvld) begin
      m_idx  = m_pend;
      m_pvld = 1'b0;
    end
    if (acc && cfg_bw != 3'd7) begin
      m_pend = {cfg_ss, cfg_m, cfg_bw};
      m_pvld = 1'b1;
    end
    m_ready = ~m_pvld;
    subc_i = W'($urandom);
    subc_q = W'($urandom);
    e.c.oval = e_oval;
    e.c.osop = e_osop;
    e.c.en   = e_oval;
    e.c.fc   = e_fc;
    e.c.done = e_done;
    e.c.err  = e_err;
    e.c.busy = e_busy;
    e.c.rdy  = m_ready;
    {e.c.ss, e.c.m, e.c.bw} = m_idx;
    e.di = subc_i;
    e.dq = subc_q;
    if (e_oval) fc_hold = e_fc;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = exp_q.pop_front();
    chk({tag, "/ctl"}, 64'(observed_ctl()), 64'(g.c));
    if (g.c.oval) chk({tag, "/data"}, 64'({osubc_i, osubc_q}), 64'({g.di, g.dq}));
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic e_busy);
    for (int i = 0; i < n; i++) begin
      ival = 1'b0;
      isop = 1'($urandom_range(1));
      frame_sync = 1'($urandom_range(1));
      cyc(tag, 1'b0, 1'b0, 1'b0, fc_hold, 1'b0, 1'b0, e_busy);
    end
  endtask

  task automatic reset_check(input string tag);
    ctl_t r;
    rst = 1'b0;
    ival = 1'b1;
    isop = 1'b0;
    frame_sync = 1'b0;
    cfg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    r = '{oval: 1'b0, osop: 1'b0, en: 1'b0, fc: 7'd0, done: 1'b0, err: 1'b0,
          busy: 1'b0, rdy: 1'b1, ecfg: 1'b0, ss: 4'd0, m: 3'd0, bw: 3'd0};
    chk({tag, "/rst_ctl"}, 64'(observed_ctl()), 64'(r));
    chk({tag, "/rst_data"}, 64'({osubc_i, osubc_q}), 64'(0));
    chk({tag, "/rst_state"}, 64'(fsm_state), 64'(ST_IDLE));
    rst = 1'b1;
    m_pvld = 1'b0;
    m_ready = 1'b1;
    m_pend = '0;
    m_idx = '0;
    fc_hold = 7'd0;
  endtask

  // Send one frame of SL-sample symbols. Optional: random ival gaps, a short
  // symbol, start dropped at a symbol, reset at a symbol, a config offer.
  task automatic send_frame(input string tag, input int gap_pct, input int short_sym,
                            input int stop_sym, input int rst_sym, input int cfg_sym,
                            input logic [9:0] cfg_word);
    logic in_frame;
    logic last;
    in_frame = 1'b0;
    for (int s = 0; s < FS; s++) begin
      if (s == stop_sym) start = 1'b0;
      if (s == rst_sym) begin
        reset_check({tag, "/mid"});
        // The stream keeps flowing after reset; nothing may come out of it.
        for (int k = 0; k < 2 * SL; k++) begin
          ival = 1'b1;
          isop = (k % SL) == 0;
          frame_sync = 1'b0;
          cyc({tag, "/post_rst"}, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      for (int k = 0; k < SL; k++) begin
        if ($urandom_range(99) < gap_pct) begin
          ival = 1'b0;
          isop = 1'($urandom_range(1));
          frame_sync = 1'($urandom_range(1));
          cyc({tag, "/gap"}, 1'b0, 1'b0, 1'b0, fc_hold, 1'b0, 1'b0, in_frame);
        end
        if (s == cfg_sym && k == 1) begin
          cfg_valid = 1'b1;
          {cfg_ss, cfg_m, cfg_bw} = cfg_word;
        end
        ival = 1'b1;
        frame_sync = (s == 0 && k == 0);
        if (s == short_sym && k == SL - 3) begin
          isop = 1'b1;
          cyc({tag, "/short"}, 1'b0, 1'b0, 1'b0, fc_hold, 1'b0, 1'b1, 1'b0);
          return;
        end
        isop = (k == 0);
        last = (s == FS - 1) && (k == SL - 1);
        cyc(tag, (s == 0 && k == 0), 1'b1, (k == 0), 7'(s), last, 1'b0, ~last);
        in_frame = 1'b1;
        cfg_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    frame_sync = 1'b0;
    ival = 1'b0;
    isop = 1'b0;
    subc_i = '0;
    subc_q = '0;
    cfg_valid = 1'b0;
    cfg_ss = 4'd0;
    cfg_m = 3'd0;
    cfg_bw = 3'd0;
    @(negedge clk);
    reset_check("init");

    // A frame-sync sample while not armed is ignored.
    ival = 1'b1; isop = 1'b1; frame_sync = 1'b1;
    cyc("unarmed", 1'b0, 1'b0, 1'b0, fc_hold, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    idle_cycles("arm", 2, 1'b0);
    chk("arm/state", 64'(fsm_state), 64'(ST_WAIT_SOF));

    // Frame 1: config {ss=1,m=2,bw=3} offered mid-frame, held until frame 2.
    send_frame("f1", 0, -1, -1, -1, 3, {4'd1, 3'd2, 3'd3});
    idle_cycles("f1_gap", 2, 1'b0);

    // Frame 2: config applied at the start sample; illegal bw=7 offered.
    send_frame("f2", 0, -1, -1, -1, 2, {4'd9, 3'd5, 3'd7});

    // Frame 3: short symbol 3 aborts; index_bw must still be 3.
    send_frame("f3", 0, 3, -1, -1, -1, 10'd0);
    chk("f3/state", 64'(fsm_state), 64'(ST_WAIT_SOF));
    chk("f3/index_bw", 64'(index_bw), 64'(3'd3));

    // Frame 4: random gaps, new config offered.
    send_frame("f4", 30, -1, -1, -1, 1, {4'd5, 3'd1, 3'd6});

    // Frame 5: gaps, another config left pending, then reset mid-frame.
    send_frame("f5", 30, -1, -1, 4, 1, {4'd2, 3'd3, 3'd4});
    chk("f5/cfg_ready", 64'(cfg_ready), 64'(1));

    // Frame 6: reset emptied the pending config, so index stays 0.
    idle_cycles("f6_arm", 2, 1'b0);
    send_frame("f6", 10, -1, -1, -1, -1, 10'd0);
    chk("f6/index", 64'({index_ss, index_M, index_bw}), 64'(0));

    // Frame 7: start dropped in symbol 2; the frame still completes.
    send_frame("f7", 0, -1, 2, -1, -1, 10'd0);
    chk("f7/state", 64'(fsm_state), 64'(ST_IDLE));
    chk("f7/busy", 64'(busy), 64'(0));
    ival = 1'b1; isop = 1'b1; frame_sync = 1'b1;
    cyc("f7/after_stop", 1'b0, 1'b0, 1'b0, fc_hold, 1'b0, 1'b0, 1'b0);
    chk("f7/queue", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
